ofm_writeback_arbiter: RTL and testbench

Round-robin scheduler that shares one 64-bit AXI write-data stream between N OFM BRAM buffer controllers. Each controller raises its full flag once a tile row is buffered. The arbiter grants exactly one full buffer at a time and routes that buffer's valid/data/ready handshake to the shared master for a fixed-length burst. It then releases the grant and rotates priority. It sits between the per-channel OFM BRAM controllers and the AXI write master.

---
 rtl/ofm_writeback_arbiter.sv | 131 +++++++++++++
 tb/tb_ofm_writeback_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback_arbiter.sv
// Round-robin arbiter that shares one AXI write-data stream between N OFM buffer controllers.
// Optional macro OFM_WB_STALL_CNT_EN adds a saturating stall_cnt output.
module ofm_writeback_arbiter #(
   parameter int N_SRC  = 4,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_SRC-1:0]          src_full,
   input  logic [N_SRC-1:0]          src_valid,
   input  logic [N_SRC*DATA_W-1:0]   src_data,
   output logic [N_SRC-1:0]          src_ready,
   input  logic [LEN_W-1:0]          burst_len,
   output logic                      m_valid,
   output logic [DATA_W-1:0]         m_data,
   output logic                      m_last,
   output logic [2:0]                m_src_id,
   input  logic                      m_ready,
   output logic                      busy,
   output logic                      burst_done
`ifdef OFM_WB_STALL_CNT_EN
   ,
   output logic [31:0]               stall_cnt
`endif
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CNT_W = LEN_W + 1;

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_grant;
   logic [IDX_W-1:0]   r_rrPtr;
   logic [CNT_W-1:0]   r_len;
   logic [CNT_W-1:0]   r_beatCnt;

   logic [DATA_W-1:0]  w_srcData [N_SRC];
   logic [N_SRC-1:0]   w_rot;
   logic [IDX_W-1:0]   w_off;
   logic [IDX_W:0]     w_sum;
   logic [IDX_W-1:0]   w_pick;
   logic [IDX_W-1:0]   w_nextPtr;
   logic               w_anyFull;
   logic               w_hs;
   logic               w_lastBeat;

   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_slice
         assign w_srcData[gi] = src_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Rotate the full vector so bit 0 is rr_ptr; the lowest set bit is then the next owner.
   always_comb begin
      w_rot     = N_SRC'({src_full, src_full} >> r_rrPtr);
      w_anyFull = |src_full;
      w_off     = '0;
      for (int j = N_SRC - 1; j >= 0; j--) begin
         if (w_rot[j]) w_off = IDX_W'(j);
      end
      w_sum  = {1'b0, r_rrPtr} + {1'b0, w_off};
      w_pick = IDX_W'((w_sum >= (IDX_W+1)'(N_SRC)) ? (w_sum - (IDX_W+1)'(N_SRC)) : w_sum);
   end

   assign w_nextPtr = (r_grant == IDX_W'(N_SRC - 1)) ? '0 : r_grant + 1'b1;

   always_comb begin
      m_valid   = 1'b0;
      m_data    = '0;
      src_ready = '0;
      if (r_state == XFER) begin
         m_valid            = src_valid[r_grant];
         m_data             = w_srcData[r_grant];
         src_ready[r_grant] = m_ready;
      end
   end

   assign w_hs       = m_valid & m_ready;
   assign w_lastBeat = (r_beatCnt == r_len - CNT_W'(1));
   assign m_last     = m_valid & w_lastBeat;
   assign m_src_id   = 3'(r_grant);
   assign busy       = (r_state != IDLE);
   assign burst_done = (r_state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_rrPtr   <= '0;
         r_len     <= '0;
         r_beatCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyFull) begin
                  r_grant   <= w_pick;
                  r_len     <= (burst_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, burst_len};
                  r_beatCnt <= '0;
                  r_state   <= XFER;
               end
            end
            XFER: begin
               if (w_hs) begin
                  r_beatCnt <= r_beatCnt + CNT_W'(1);
                  if (w_lastBeat) r_state <= DONE;
               end
            end
            DONE: begin
               // Priority rotates here so the finished source's full flag has settled before re-arbitration.
               r_rrPtr <= w_nextPtr;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef OFM_WB_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((r_state == XFER) && m_valid && !m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ofm_writeback_arbiter.sv
// Directed bench for ofm_writeback_arbiter: table of bursts plus hand sequences for
// reset mid-burst and (when OFM_WB_STALL_CNT_EN is defined) the stall counter.
module tb_ofm_writeback_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    src_full;
   logic [3:0]    src_valid;
   logic [255:0]  src_data;
   logic [3:0]    src_ready;
   logic [3:0]    burst_len;
   logic          m_valid;
   logic [63:0]   m_data;
   logic          m_last;
   logic [2:0]    m_src_id;
   logic          m_ready;
   logic          busy;
   logic          burst_done;
`ifdef OFM_WB_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int beatIdx [4];

   typedef struct {
      bit         doReset;
      logic [3:0] setFull;
      logic [3:0] burstLen;
      int         expSrc;
      int         expLen;
      int         expWait;
      bit         toggle;
      bit         gap;
      bit         noDrop;
   } vec_t;

   vec_t vecs [13];

   ofm_writeback_arbiter #(.N_SRC(4), .DATA_W(64), .LEN_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_full   (src_full),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .burst_len  (burst_len),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_src_id   (m_src_id),
      .m_ready    (m_ready),
      .busy       (busy),
      .burst_done (burst_done)
`ifdef OFM_WB_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Each source streams {0xCAFE0000+i, beat index}, advancing only on its own handshake.
   task automatic updateData();
      for (int i = 0; i < 4; i++) src_data[i*64 +: 64] = {32'hCAFE0000 + 32'(i), 32'(beatIdx[i])};
   endtask

   task automatic tick();
      logic [3:0] hs;
      hs = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (hs[i]) beatIdx[i]++;
      updateData();
   endtask

   task automatic applyStimulus(input logic [3:0] fullSet, input logic [3:0] len);
      src_full  = src_full | fullSet;
      burst_len = len;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      src_full  = 4'h0;
      src_valid = 4'hF;
      m_ready   = 1'b1;
      burst_len = 4'd4;
      for (int i = 0; i < 4; i++) beatIdx[i] = 0;
      updateData();
      #1;
      checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_m_last", 64'(m_last), 64'd0);
      checkOutput("rst_m_data", m_data, 64'd0);
      checkOutput("rst_m_src_id", 64'(m_src_id), 64'd0);
      checkOutput("rst_src_ready", 64'(src_ready), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_burst_done", 64'(burst_done), 64'd0);
`ifdef OFM_WB_STALL_CNT_EN
      checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic doBurst(input int src, input int len, input int expWait,
                          input bit toggle, input bit gap, input bit noDrop);
      int w = 0;
      int n = 0;
      int k = 0;
      logic ev;
      logic mr;
      while (!m_valid && w < 20) begin
         tick();
         w++;
      end
      checkOutput("grant_wait", 64'(w), 64'(expWait));
      checkOutput("grant_src", 64'(m_src_id), 64'(src));
      beatIdx[src] = 0;
      updateData();
      burst_len = 4'd1;
      while (n < len && k < 200) begin
         mr        = toggle ? ((k % 2) == 0) : 1'b1;
         ev        = !(gap && (k == 2 || k == 3));
         m_ready   = mr;
         src_valid = 4'hF;
         src_valid[src] = ev;
         #1;
         checkOutput("m_valid", 64'(m_valid), 64'(ev));
         checkOutput("src_ready", 64'(src_ready), 64'(4'(mr) << src));
         checkOutput("m_last", 64'(m_last), 64'(ev && (n == len - 1)));
         checkOutput("busy", 64'(busy), 64'd1);
         checkOutput("burst_done_early", 64'(burst_done), 64'd0);
         checkOutput("m_src_id_stable", 64'(m_src_id), 64'(src));
         if (ev) checkOutput("m_data", m_data, {32'hCAFE0000 + 32'(src), 32'(n)});
         if (ev && mr) n++;
         tick();
         k++;
         if (n == len && !noDrop) src_full[src] = 1'b0;
      end
      checkOutput("beats", 64'(n), 64'(len));
      checkOutput("done_pulse", 64'(burst_done), 64'd1);
      checkOutput("done_m_valid", 64'(m_valid), 64'd0);
      checkOutput("done_src_ready", 64'(src_ready), 64'd0);
      checkOutput("done_busy", 64'(busy), 64'd1);
      m_ready   = 1'b1;
      src_valid = 4'hF;
   endtask

   initial begin
      int w;
      //            rst   full    len   src len wait tog  gap  noDrop
      vecs[0]  = '{1'b1, 4'b0100, 4'd4, 2, 4,  1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'b1011, 4'd4, 3, 4,  2, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'b0000, 4'd4, 0, 4,  2, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 4'b0000, 4'd4, 1, 4,  2, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 4'b1011, 4'd4, 0, 4,  1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'b0000, 4'd4, 1, 4,  2, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'b0000, 4'd4, 3, 4,  2, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 4'b0001, 4'd3, 0, 3,  1, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 4'b0010, 4'd0, 1, 16, 2, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 4'b0001, 4'd2, 0, 2,  1, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 4'b0000, 4'd2, 0, 2,  2, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 4'b0100, 4'd2, 2, 2,  2, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 4'b0000, 4'd2, 0, 2,  2, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].doReset) doReset();
         applyStimulus(vecs[i].setFull, vecs[i].burstLen);
         doBurst(vecs[i].expSrc, vecs[i].expLen, vecs[i].expWait,
                 vecs[i].toggle, vecs[i].gap, vecs[i].noDrop);
      end

      // Reset mid-burst with rr_ptr currently 1: afterwards source 0 must win over source 1.
      applyStimulus(4'b0100, 4'd4);
      w = 0;
      while (!m_valid && w < 20) begin
         tick();
         w++;
      end
      checkOutput("mid_grant_src", 64'(m_src_id), 64'd2);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("mid_rst_m_data", m_data, 64'd0);
      checkOutput("mid_rst_m_last", 64'(m_last), 64'd0);
      checkOutput("mid_rst_src_ready", 64'(src_ready), 64'd0);
      checkOutput("mid_rst_m_src_id", 64'(m_src_id), 64'd0);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      src_full  = 4'b0011;
      burst_len = 4'd4;
      tick();
      rst_n = 1'b1;
      doBurst(0, 4, 1, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'd4);
      doBurst(1, 4, 2, 1'b0, 1'b0, 1'b0);

`ifdef OFM_WB_STALL_CNT_EN
      doReset();
      m_ready = 1'b0;
      applyStimulus(4'b0001, 4'd4);
      tick();
      for (int i = 0; i < 5; i++) tick();
      checkOutput("stall_cnt", 64'(stall_cnt), 64'd5);
      doBurst(0, 4, 0, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_cnt_hold", 64'(stall_cnt), 64'd5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
